// File: rtl/lsu_mem_ctrl.sv
// Load/store controller for a word-addressed 64-bit data memory without byte enables.
// Sub-word stores are read-modify-write; define LSU_ALIGN_CHECK_EN to reject misaligned requests.
module lsu_mem_ctrl #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] buf_q, buf_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [2:0]  size_lsbs;
    logic        out_of_range;
    logic [63:0] acc_addr;
    logic        acc_err;
    logic [5:0]  lane_shift;
    logic [63:0] lane_mask;

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    size_mask = 64'h0000_0000_0000_00ff;
            2'd1:    size_mask = 64'h0000_0000_0000_ffff;
            2'd2:    size_mask = 64'h0000_0000_ffff_ffff;
            default: size_mask = 64'hffff_ffff_ffff_ffff;
        endcase
    endfunction

    function automatic logic [63:0] extract(input logic [63:0] word, input logic [5:0] shift,
                                            input logic [1:0] size, input logic sgn);
        logic [63:0] lane;
        logic        msb;
        lane = (word >> shift) & size_mask(size);
        case (size)
            2'd0:    msb = lane[7];
            2'd1:    msb = lane[15];
            2'd2:    msb = lane[31];
            default: msb = 1'b0;
        endcase
        extract = (sgn && msb) ? (lane | ~size_mask(size)) : lane;
    endfunction

    // Address bits that must be zero for a naturally aligned access of req_size.
    always_comb begin
        case (req_size)
            2'd0:    size_lsbs = 3'b000;
            2'd1:    size_lsbs = 3'b001;
            2'd2:    size_lsbs = 3'b011;
            default: size_lsbs = 3'b111;
        endcase
    end

    // The memory ends on a word boundary, so the word index alone decides the range.
    assign out_of_range = {3'b000, req_addr[63:3]} >= 64'(MEM_WORDS);

`ifdef LSU_ALIGN_CHECK_EN
    assign acc_addr = req_addr;
    assign acc_err  = out_of_range || ((req_addr[2:0] & size_lsbs) != 3'b000);
`else
    assign acc_addr = {req_addr[63:3], req_addr[2:0] & ~size_lsbs};
    assign acc_err  = out_of_range;
`endif

    assign lane_shift = {addr_q[2:0], 3'b000};
    assign lane_mask  = size_mask(size_q) << lane_shift;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        signed_d   = signed_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        rdata_d    = '0;
        err_d      = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d     = req_we;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = acc_addr;
                    wdata_d  = req_wdata;
                    if (acc_err) begin
                        state_d = StResp;
                        err_d   = 1'b1;
                    end else if (req_we && req_size == 2'd3) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                mem_read = 1'b1;
                mem_addr = {3'b000, addr_q[63:3]};
                buf_d    = mem_rdata;
                if (we_q) begin
                    state_d = StWrite;
                end else begin
                    rdata_d = extract(mem_rdata, lane_shift, size_q, signed_q);
                    state_d = StResp;
                end
            end
            StWrite: begin
                mem_write = 1'b1;
                mem_addr  = {3'b000, addr_q[63:3]};
                if (size_q == 2'd3) begin
                    mem_wdata = wdata_q;
                end else begin
                    mem_wdata = (buf_q & ~lane_mask)
                              | ((wdata_q & size_mask(size_q)) << lane_shift);
                end
                state_d = StResp;
            end
            StResp: begin
                resp_valid = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            buf_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            buf_q    <= buf_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule
